// File: rtl/rv32i_rf_pkg.sv
// Shared constants and types for the RV32I register-file write path.
// The state enum serves the optional post-reset clear (RF_CLEAR_ON_RESET_EN).
package rv32i_rf_pkg;
  localparam int XLEN     = 32;
  localparam int AW       = 5;
  localparam int NUM_REGS = 32;

  localparam logic [AW-1:0] REG_ZERO = 5'd0;
  localparam logic [AW-1:0] REG_LAST = 5'd31;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_e;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin valid/ready arbiter: one-hot grant searched upward from rr_ptr,
// pointer moves past the winner whenever a transfer happens.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [N-1:0]  valid,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          transfer
);
  logic [PW-1:0] rr_ptr_r;
  logic [N-1:0]  grant_s;
  logic [PW-1:0] gidx_s;
  logic          found_s;

  // Pick the first valid requester at or after rr_ptr, wrapping at N.
  always_comb begin
    int idx_v;
    grant_s = '0;
    gidx_s  = '0;
    found_s = 1'b0;
    idx_v   = 0;
    for (int k = 0; k < N; k++) begin
      idx_v = int'(rr_ptr_r) + k;
      if (idx_v >= N) begin
        idx_v = idx_v - N;
      end else begin
        idx_v = idx_v;
      end
      for (int j = 0; j < N; j++) begin
        if (!found_s && en && (j == idx_v) && valid[j]) begin
          grant_s[j] = 1'b1;
          gidx_s     = PW'(j);
          found_s    = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
    end
  end

  // Ready must never leak out while the block is held in reset.
  assign grant     = rst_n ? grant_s : '0;
  assign grant_idx = gidx_s;
  assign transfer  = rst_n & found_s;

  // Priority pointer: one past the winner on transfer, unchanged otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= '0;
    end else if (found_s) begin
      rr_ptr_r <= (gidx_s == PW'(N - 1)) ? '0 : gidx_s + PW'(1);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port controller: round-robin sharing among NUM_REQ writeback
// sources; with RF_CLEAR_ON_RESET_EN it first clears x1..x31 after reset.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = rv32i_rf_pkg::XLEN,
  parameter int AW      = rv32i_rf_pkg::AW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*AW-1:0]   req_addr,
  input  logic [NUM_REQ*XLEN-1:0] req_data,
  output logic                    rf_write_enable,
  output logic [AW-1:0]           rf_write_addr,
  output logic [XLEN-1:0]         rf_write_data,
  output logic [1:0]              rf_write_src,
  output logic                    init_busy
);
  import rv32i_rf_pkg::*;

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic            run_s;
  logic [AW-1:0]   clr_addr_s;
  logic            transfer_s;
  logic [PW-1:0]   gidx_s;
  logic [AW-1:0]   sel_addr_s;
  logic [XLEN-1:0] sel_data_s;
  logic            we_r;
  logic [AW-1:0]   addr_r;
  logic [XLEN-1:0] data_r;
  logic [1:0]      src_r;

`ifdef RF_CLEAR_ON_RESET_EN
  rf_state_e     state_r;
  rf_state_e     state_nxt_s;
  logic [AW-1:0] clr_idx_r;

  // State and clear counter; the counter only moves while clearing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= INIT;
      clr_idx_r <= AW'(1);
    end else begin
      state_r <= state_nxt_s;
      if (state_r == INIT) begin
        clr_idx_r <= clr_idx_r + AW'(1);
      end else begin
        clr_idx_r <= clr_idx_r;
      end
    end
  end

  // Leave INIT on the edge that issues the x31 clear write.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      INIT: begin
        if (clr_idx_r == REG_LAST) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = INIT;
        end
      end
      RUN:     state_nxt_s = RUN;
      default: state_nxt_s = INIT;
    endcase
  end

  assign clr_addr_s = clr_idx_r;
`else
  rf_state_e state_r;
  assign state_r    = RUN;
  assign clr_addr_s = REG_ZERO;
`endif

  assign run_s     = (state_r == RUN);
  assign init_busy = ~run_s;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (run_s),
    .valid     (req_valid),
    .grant     (req_ready),
    .grant_idx (gidx_s),
    .transfer  (transfer_s)
  );

  // Steer the granted requester's address and data onto the capture path.
  always_comb begin
    sel_addr_s = REG_ZERO;
    sel_data_s = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (gidx_s == PW'(j)) begin
        sel_addr_s = req_addr[j*AW +: AW];
        sel_data_s = req_data[j*XLEN +: XLEN];
      end else begin
        sel_addr_s = sel_addr_s;
        sel_data_s = sel_data_s;
      end
    end
  end

  // Registered write port; x0 transfers are consumed but never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r   <= 1'b0;
      addr_r <= '0;
      data_r <= '0;
      src_r  <= 2'd0;
    end else if (!run_s) begin
      we_r   <= 1'b1;
      addr_r <= clr_addr_s;
      data_r <= '0;
      src_r  <= 2'd0;
    end else if (transfer_s && (sel_addr_s != REG_ZERO)) begin
      we_r   <= 1'b1;
      addr_r <= sel_addr_s;
      data_r <= sel_data_s;
      src_r  <= 2'(gidx_s);
    end else begin
      we_r   <= 1'b0;
      addr_r <= addr_r;
      data_r <= data_r;
      src_r  <= src_r;
    end
  end

  assign rf_write_enable = we_r;
  assign rf_write_addr   = addr_r;
  assign rf_write_data   = data_r;
  assign rf_write_src    = src_r;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a reference model predicts grants and
// the registered write port; a separate monitor pops and compares every cycle.
module tb_regfile_wb_arbiter;
  localparam int NREQ = 2;
  localparam int XL   = 32;
  localparam int AWID = 5;
`ifdef RF_CLEAR_ON_RESET_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AWID-1:0] req_addr = '0;
  logic [NREQ*XL-1:0]   req_data = '0;
  logic                 rf_write_enable;
  logic [AWID-1:0]      rf_write_addr;
  logic [XL-1:0]        rf_write_data;
  logic [1:0]           rf_write_src;
  logic                 init_busy;

  regfile_wb_arbiter #(.NUM_REQ(NREQ), .XLEN(XL), .AW(AWID)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_addr        (req_addr),
    .req_data        (req_data),
    .rf_write_enable (rf_write_enable),
    .rf_write_addr   (rf_write_addr),
    .rf_write_data   (rf_write_data),
    .rf_write_src    (rf_write_src),
    .init_busy       (init_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [1:0]  src;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cycle = 0;
  int          m_ptr = 0;
  bit          m_init = CLR_EN;
  int          m_clr = 1;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic [1:0]  m_src = '0;
  logic [31:0] m_rf[32];
  logic [31:0] d_rf[32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cycle, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cycle = cycle + 1;
  end

  // Reference model: predicts ready now and the write port after the next edge.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m_ptr = 0; m_init = CLR_EN; m_clr = 1;
      m_addr = '0; m_data = '0; m_src = '0;
      q.delete();
    end else begin
      exp_t e;
      logic [NREQ-1:0] exp_ready;
      int g;
      exp_ready = '0;
      g = -1;
      check("init_busy", init_busy, m_init);
      if (m_init) begin
        m_addr = 5'(m_clr); m_data = '0; m_src = '0;
        e.en = 1'b1;
        m_clr++;
        if (m_clr > 31) m_init = 1'b0;
      end else begin
        e.en = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
          int idx;
          idx = (m_ptr + k) % NREQ;
          if (g < 0 && req_valid[idx]) g = idx;
        end
        if (g >= 0) begin
          logic [4:0] a;
          exp_ready[g] = 1'b1;
          m_ptr = (g + 1) % NREQ;
          a = req_addr[g*AWID +: AWID];
          if (a != 5'd0) begin
            e.en = 1'b1;
            m_addr = a;
            m_data = req_data[g*XL +: XL];
            m_src = 2'(g);
          end
        end
      end
      check("req_ready", req_ready, exp_ready);
      e.addr = m_addr; e.data = m_data; e.src = m_src; e.cyc = cycle + 1;
      q.push_back(e);
    end
  end

  // Monitor: compares the write port against the oldest due expectation.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      check("rst_we", rf_write_enable, 1'b0);
      check("rst_addr", rf_write_addr, 5'd0);
      check("rst_data", rf_write_data, 32'd0);
      check("rst_ready", req_ready, '0);
    end else if (q.size() > 0 && q[0].cyc == cycle) begin
      exp_t e;
      e = q.pop_front();
      check("we", rf_write_enable, e.en);
      check("addr", rf_write_addr, e.addr);
      check("data", rf_write_data, e.data);
      check("src", rf_write_src, e.src);
      if (e.en) m_rf[e.addr] = e.data;
      if (rf_write_enable) d_rf[rf_write_addr] = rf_write_data;
    end else if (q.size() > 0 && q[0].cyc < cycle) begin
      check("stale_exp", 64'(q[0].cyc), 64'(cycle));
      void'(q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
    req_valid[i] = v;
    req_addr[i*AWID +: AWID] = a;
    req_data[i*XL +: XL] = d;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = '1;
    #1;
    check("rst_now_we", rf_write_enable, 1'b0);
    check("rst_now_src", rf_write_src, 2'd0);
    check("rst_now_ready", req_ready, '0);
    check("rst_now_busy", init_busy, CLR_EN);
    repeat (3) @(posedge clk);
    #1;
    req_valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic wait_init();
    int t;
    t = 0;
    while (init_busy && t < 100) begin
      step();
      t++;
    end
    check("init_done", init_busy, 1'b0);
  endtask

  task automatic random_burst(input int n);
    logic [NREQ-1:0] acc;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && !acc[i]) begin
          if ($urandom_range(9) == 0) req_valid[i] = 1'b0;
        end else begin
          logic [4:0] a;
          a = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
          drive(i, ($urandom_range(99) < 60), a, $urandom);
        end
      end
    end
    req_valid = '0;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin
      m_rf[r] = '0;
      d_rf[r] = '0;
    end
    #2;
    apply_reset();
    wait_init();

    drive(0, 1'b1, 5'd5, 32'hDEADBEEF);
    step(); req_valid = '0; step(); step();
    check("x5", d_rf[5], 32'hDEADBEEF);

    drive(0, 1'b1, 5'd3, 32'h11111111);
    drive(1, 1'b1, 5'd4, 32'h22222222);
    repeat (6) step();
    req_valid = '0; step();

    drive(1, 1'b1, 5'd0, 32'h12345678);
    step(); req_valid = '0; step(); step();
    check("x0", d_rf[0], 32'd0);

    drive(0, 1'b1, 5'd7, 32'h0000000A);
    drive(1, 1'b1, 5'd7, 32'h0000000B);
    step(); req_valid[0] = 1'b0; step(); req_valid = '0; step(); step();
    check("x7", d_rf[7], 32'h0000000B);

    random_burst(400);
    step();
    drive(0, 1'b1, 5'd9, 32'hCAFEF00D);
    drive(1, 1'b1, 5'd10, 32'hBEEFCAFE);
    step();
    apply_reset();
    if (CLR_EN) begin
      int t;
      t = 0;
      while (m_clr != 10 && t < 100) begin
        step();
        t++;
      end
      check("clr_reach10", 64'(m_clr), 64'd10);
      apply_reset();
    end
    wait_init();
    random_burst(100);
    repeat (3) step();

    for (int r = 0; r < 32; r++) check("rf_readback", d_rf[r], m_rf[r]);
    check("queue_drained", 64'(q.size() <= 1), 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port controller for the RV32I register file: shares the single write port among NUM_REQ writeback requesters (ALU, load unit, CSR unit, ...) with round-robin valid/ready arbitration, and optionally sequences a clear of x1..x31 after reset. It sits between the execute/writeback stages and the register file's `write_enable`/`write_addr`/`write_data` inputs. Outputs to the register file are registered.

## Interface
- NUM_REQ, 2, number of writeback requesters (2..4)
- XLEN, 32, data width
- AW, 5, register address width
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  requester i has a write pending
- req_ready  out  NUM_REQ  requester i's write accepted this cycle (one-hot or zero)
- req_addr  in  NUM_REQ*AW  destination register, requester i at bits [i*AW +: AW]
- req_data  in  NUM_REQ*XLEN  write data, requester i at bits [i*XLEN +: XLEN]
- rf_write_enable  out  1  to register file `write_enable`
- rf_write_addr  out  AW  to register file `write_addr`
- rf_write_data  out  XLEN  to register file `write_data`
- rf_write_src  out  2  index of requester that produced the current write (0 during clear)
- init_busy  out  1  clear sequence in progress; no requests accepted

## Operation
- States: INIT (clear x1..x31), RUN (arbitrate). INIT exists only with the macro; otherwise RUN only.
- INIT: 5-bit counter clr_idx starts at 1; each cycle issue write clr_idx <- 0, increment; after issuing x31 go to RUN. All req_ready = 0, init_busy = 1.
- RUN: rr_ptr (reset 0) is highest-priority index; search upward from rr_ptr with wrap for first req_valid; assert req_ready for that one only.
- Transfer when req_valid[i] && req_ready[i]; rr_ptr <- (i+1) mod NUM_REQ. No transfer: rr_ptr unchanged.
- Transfer with addr 0: accepted (ready asserted, rr_ptr advances) but rf_write_enable stays 0 next cycle; x0 never written.
- Transfer with addr != 0: next cycle rf_write_enable=1, addr/data/src = captured values. No transfer: rf_write_enable=0, addr/data/src hold previous values.
- Requesters must hold addr/data stable while valid && !ready; valid may drop without a transfer.
- Same address from two requesters in one cycle: only the granted one is written; the other waits its turn (later write wins in the register file).
- req_ready is combinational from req_valid, rr_ptr, state; forced 0 while rst_n low.

## Timing
- Reset values: rf_write_enable 0, rf_write_addr 0, rf_write_data 0, rf_write_src 0, req_ready 0, rr_ptr 0, clr_idx 1, init_busy 1 (macro) / 0 (no macro).
- Acceptance latency 0 (ready same cycle as valid when granted); write-port latency 1 cycle after transfer; data readable from register file 2 cycles after transfer.
- Throughput: one write per cycle; a continuously valid requester waits at most NUM_REQ-1 cycles.
- Clear: first clear write on the first edge after rst_n rises; 31 cycles with rf_write_enable=1; init_busy falls in the same cycle the x31 write is driven; first request accepted in the next cycle.
- Reset asserted mid-clear or mid-stream: immediately return to reset values; clear restarts from x1; accepted-but-unissued write is lost.

## Configuration
- RF_CLEAR_ON_RESET_EN defined: INIT state and 31-cycle clear after reset; init_busy as above.
- Undefined: no clr_idx, no INIT; RUN from reset; init_busy tied 0; register contents after reset undefined.

## Structure
- Shared package rv32i_rf_pkg: XLEN, AW, NUM_REGS=32, REG_ZERO=5'd0, state enum {INIT, RUN}.
- One sub-module: rr_arbiter (NUM_REQ-wide valid -> one-hot grant, rr_ptr update on transfer); reusable for other shared ports.

## Test plan
- Clear (macro on): deassert rst_n -> 31 consecutive writes addr 1..31 data 0, init_busy 0 after x31, then readback of all 32 registers = 0.
- Single requester: req 0 valid addr 5 data 0xDEADBEEF -> ready same cycle, next cycle enable=1 addr 5 data 0xDEADBEEF src 0; register reads 0xDEADBEEF.
- Contention: both valid every cycle, addrs 3/4 -> grants alternate 0,1,0,1; rr_ptr wrap verified; no requester waits >1 cycle.
- x0 write: req 1 addr 0 data 0x12345678 -> ready asserted, rf_write_enable stays 0, x0 reads 0.
- Same address: req 0 addr 7 data 0xA, req 1 addr 7 data 0xB, rr_ptr 0 -> x7=0xA then 0xB over two cycles.
- Reset mid-clear at clr_idx 10 -> outputs reset values immediately; clear restarts at x1 after release.
